// File: rtl/sha256_pkg.sv
// Shared SHA-256 datapath definitions: word width, rotate constants and the
// reference rotate plus the Sigma/sigma mixers built on it.
package sha256_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned ROT_AMT_W = $clog2(WORD_W);

  localparam int unsigned ROT_2  = 2;
  localparam int unsigned ROT_6  = 6;
  localparam int unsigned ROT_7  = 7;
  localparam int unsigned ROT_11 = 11;
  localparam int unsigned ROT_13 = 13;
  localparam int unsigned ROT_17 = 17;
  localparam int unsigned ROT_18 = 18;
  localparam int unsigned ROT_19 = 19;
  localparam int unsigned ROT_22 = 22;
  localparam int unsigned ROT_25 = 25;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [ROT_AMT_W-1:0] rot_amt_t;

  // Rotating the doubled word keeps amt=0 free of a shift-by-WORD_W term.
  function automatic word_t rotr(input word_t word, input rot_amt_t amt);
    logic [2*WORD_W-1:0] dbl;
    dbl = {word, word} >> amt;
    return dbl[WORD_W-1:0];
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, rot_amt_t'(ROT_2)) ^ rotr(x, rot_amt_t'(ROT_13)) ^
           rotr(x, rot_amt_t'(ROT_22));
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, rot_amt_t'(ROT_6)) ^ rotr(x, rot_amt_t'(ROT_11)) ^
           rotr(x, rot_amt_t'(ROT_25));
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, rot_amt_t'(ROT_7)) ^ rotr(x, rot_amt_t'(ROT_18)) ^
           (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, rot_amt_t'(ROT_17)) ^ rotr(x, rot_amt_t'(ROT_19)) ^
           (x >> 10);
  endfunction

endpackage

// File: rtl/right_cyclic_shift_chk.sv
// Protocol checker for right_cyclic_shift: valid follows the accepted input by
// one cycle and the result holds when nothing was accepted.
module right_cyclic_shift_chk #(
  parameter int unsigned WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  input logic             in_valid,
  input logic             out_valid,
  input logic [WIDTH-1:0] rot_q
);

  logic armed_q;

  // Armed once a full clock edge has passed with reset released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  a_valid_follows : assert property (@(posedge clk) disable iff (!rst_n)
    armed_q |-> (out_valid == $past(in_valid)));

  a_hold_when_idle : assert property (@(posedge clk) disable iff (!rst_n)
    (armed_q && !$past(in_valid)) |-> (rot_q == $past(rot_q)));

endmodule

// File: rtl/rotr_stage.sv
// One barrel-rotator stage: rotates right by 2**STAGE when en_i is high,
// otherwise passes data_i through unchanged.
module rotr_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STAGE = 0
) (
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int unsigned STEP = 1 << STAGE;

  // Select between the fixed-distance rotate and the bypass.
  always_comb begin
    data_o = data_i;
    if (en_i) begin
      data_o = {data_i[STEP-1:0], data_i[WIDTH-1:STEP]};
    end else begin
      data_o = data_i;
    end
  end

endmodule

// File: rtl/right_cyclic_shift.sv
// 32-bit ROTR primitive: a combinational fixed-amount rotate on out and a
// runtime-amount logarithmic rotator with a one-cycle registered result.
module right_cyclic_shift
  import sha256_pkg::*;
#(
  parameter  int unsigned WIDTH = WORD_W,
  parameter  int unsigned SHIFT = 1,
  localparam int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] num,
  output logic [WIDTH-1:0] out,
  input  logic [AMT_W-1:0] amt,
  input  logic             in_valid,
  output logic [WIDTH-1:0] rot_q,
  output logic             out_valid
);

  generate
    if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
      $error("right_cyclic_shift: WIDTH must be a power of two >= 2");
    end
    if (SHIFT >= WIDTH) begin : g_bad_shift
      $error("right_cyclic_shift: SHIFT must be below WIDTH");
    end
  endgenerate

  // Static path: the shared reference rotate when the width matches the
  // SHA-256 word, a doubled-word rotate otherwise.
  generate
    if (WIDTH == WORD_W) begin : g_static_word
      localparam rot_amt_t SHIFT_AMT = rot_amt_t'(SHIFT);
      assign out = rotr(num, SHIFT_AMT);
    end else begin : g_static_generic
      logic [2*WIDTH-1:0] dbl_s;
      assign dbl_s = {num, num} >> SHIFT;
      assign out   = dbl_s[WIDTH-1:0];
    end
  endgenerate

  logic [AMT_W:0][WIDTH-1:0] stage_s;
  logic [WIDTH-1:0]          rot_d;
  logic [WIDTH-1:0]          rot_q_q;
  logic                      valid_d;
  logic                      valid_q;

  assign stage_s[0] = num;

  generate
    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
      rotr_stage #(
        .WIDTH (WIDTH),
        .STAGE (k)
      ) u_stage (
        .en_i   (amt[k]),
        .data_i (stage_s[k]),
        .data_o (stage_s[k+1])
      );
    end
  endgenerate

  // Capture only when qualified, so an unknown amt with in_valid low never
  // reaches the result register.
  always_comb begin
    rot_d   = rot_q_q;
    valid_d = 1'b0;
    if (in_valid) begin
      rot_d   = stage_s[AMT_W];
      valid_d = 1'b1;
    end else begin
      rot_d   = rot_q_q;
      valid_d = 1'b0;
    end
  end

  // Result and valid registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q_q <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
    end else begin
      rot_q_q <= rot_d;
      valid_q <= valid_d;
    end
  end

  assign rot_q     = rot_q_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_right_cyclic_shift.sv
// Directed and swept checks of the static rotate, the registered barrel
// rotator, valid gating and asynchronous reset behaviour.
module tb_right_cyclic_shift;

  logic        clk;
  logic        rst_n;
  logic [31:0] num;
  logic [4:0]  amt;
  logic        in_valid;
  logic [31:0] out1;
  logic [31:0] out2;
  logic [31:0] rot_q;
  logic        out_valid;
  logic [31:0] rot_q2;
  logic        out_valid2;

  int n_checks;
  int n_fail;

  right_cyclic_shift #(.SHIFT(1)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .num       (num),
    .out       (out1),
    .amt       (amt),
    .in_valid  (in_valid),
    .rot_q     (rot_q),
    .out_valid (out_valid)
  );

  right_cyclic_shift #(.SHIFT(2)) u_dut_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .num       (num),
    .out       (out2),
    .amt       (amt),
    .in_valid  (in_valid),
    .rot_q     (rot_q2),
    .out_valid (out_valid2)
  );

  right_cyclic_shift_chk #(.WIDTH(32)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .out_valid (out_valid),
    .rot_q     (rot_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
    end
  endtask

  // Independent model: rotate right one bit at a time.
  function automatic logic [31:0] model_rotr(input logic [31:0] w, input int a);
    logic [31:0] r;
    r = w;
    for (int i = 0; i < a; i++) r = {r[0], r[31:1]};
    return r;
  endfunction

  task automatic step(input logic v, input logic [31:0] n, input logic [4:0] a);
    @(negedge clk);
    in_valid = v;
    num      = n;
    amt      = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rn;
    logic [4:0]  ra;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    num      = 32'h0;
    amt      = 5'd0;

    // Static path, no clock involvement.
    num = 32'hF000_0000; #1;
    chk("static_s1_f0", out1, 32'h7800_0000);
    num = 32'h0000_0001; #1;
    chk("static_s2_one", out2, 32'h4000_0000);
    chk("static_s1_one", out1, 32'h8000_0000);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rot_q", rot_q, 32'h0);
    chk("reset_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 32'hF000_0000, 5'd4);
    chk("first_rot", rot_q, 32'h0F00_0000);
    chk("first_valid", {31'b0, out_valid}, 32'h1);

    step(1'b1, 32'h1234_5678, 5'd0);
    chk("amt0", rot_q, 32'h1234_5678);
    step(1'b1, 32'h1234_5678, 5'd31);
    chk("amt31", rot_q, 32'h2468_ACF0);
    step(1'b1, 32'h1234_5678, 5'd16);
    chk("amt16", rot_q, 32'h5678_1234);

    // Valid gating: one accepted input, then idle cycles with changing data.
    step(1'b1, 32'h8000_0000, 5'd1);
    chk("gate_rot", rot_q, 32'h4000_0000);
    chk("gate_valid1", {31'b0, out_valid}, 32'h1);
    step(1'b0, 32'hDEAD_BEEF, 5'd7);
    chk("gate_hold1", rot_q, 32'h4000_0000);
    chk("gate_valid0", {31'b0, out_valid}, 32'h0);
    step(1'b0, 32'h0BAD_F00D, 5'd13);
    chk("gate_hold2", rot_q, 32'h4000_0000);
    chk("gate_valid0b", {31'b0, out_valid}, 32'h0);
    step(1'b0, 32'h5555_AAAA, 5'bxxxxx);
    chk("x_amt_hold", rot_q, 32'h4000_0000);

    // Back-to-back accepted inputs.
    step(1'b1, 32'h0000_0001, 5'd1);
    chk("b2b_1", rot_q, 32'h8000_0000);
    chk("b2b_v1", {31'b0, out_valid}, 32'h1);
    step(1'b1, 32'h0000_0001, 5'd2);
    chk("b2b_2", rot_q, 32'h4000_0000);
    chk("b2b_v2", {31'b0, out_valid}, 32'h1);
    step(1'b1, 32'h0000_0001, 5'd3);
    chk("b2b_3", rot_q, 32'h2000_0000);
    chk("b2b_v3", {31'b0, out_valid}, 32'h1);

    // Reset asserted mid-cycle with a capture pending.
    @(negedge clk);
    in_valid = 1'b1;
    num      = 32'hCAFE_0001;
    amt      = 5'd5;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rot", rot_q, 32'h0);
    chk("midrst_valid", {31'b0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    chk("midrst_hold_rot", rot_q, 32'h0);
    chk("midrst_hold_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rel_valid", {31'b0, out_valid}, 32'h0);
    chk("post_rel_rot", rot_q, 32'h0);
    step(1'b1, 32'hCAFE_0001, 5'd5);
    chk("post_rel_cap", rot_q, 32'h0E57_F000);

    // All-ones and all-zeros words are rotation-invariant.
    for (int a = 0; a < 32; a++) begin
      step(1'b1, 32'hFFFF_FFFF, 5'(a));
      chk("ones", rot_q, 32'hFFFF_FFFF);
    end
    step(1'b1, 32'h0, 5'd9);
    chk("zeros", rot_q, 32'h0);

    for (int i = 0; i < 1000; i++) begin
      rn = $urandom;
      ra = 5'($urandom_range(31, 0));
      step(1'b1, rn, ra);
      chk("rand", rot_q, model_rotr(rn, int'(ra)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
